fwd_scoreboard: RTL

//   Parametrised operand-forwarding and hazard unit for the MIPS pipeline, sitting at the ID/EXE boundary.
//   - Keeps a shift-register scoreboard of in-flight register writes, one entry per post-ID stage (EXE..WB).
//   - Selects the newest available value for rs/rt from the regfile or any later stage.
//   - Raises stall for a load-use hazard, or for any operand whose producer has not yet produced its value.
//   - Generalises the fixed 2-bit EXE forwarding mux to STAGES stages, with per-class result-ready stages.

---
 rtl/fwd_scoreboard.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and hazard unit at the ID/EXE boundary: a shift-register
// scoreboard of in-flight register writes drives per-operand bypass selection.

module fwd_lookup #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STAGES     = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 1
) (
  input  logic [STAGES-1:0]             v_i,
  input  logic [STAGES-1:0]             wen_i,
  input  logic [STAGES-1:0]             load_i,
  input  logic [STAGES-1:0][ADDR_W-1:0] waddr_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DATA_W-1:0]             rf_data_i,
  input  logic [STAGES*DATA_W-1:0]      stage_data_i,
  output logic [DATA_W-1:0]             op_o,
  output logic [3:0]                    sel_o,
  output logic                          blocked_o
);
  int   hit_idx;
  logic hit, hit_ld, ready;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    hit_ld  = 1'b0;
    // Scan oldest to youngest so the youngest (lowest index) match wins.
    for (int k = STAGES-1; k >= 0; k--) begin
      if (v_i[k] && wen_i[k] && waddr_i[k] == addr_i && addr_i != '0) begin
        hit     = 1'b1;
        hit_idx = k;
        hit_ld  = load_i[k];
      end
    end
    ready     = hit_idx >= (hit_ld ? LOAD_READY : ALU_READY);
    blocked_o = hit && !ready;
    sel_o     = 4'd0;
    op_o      = rf_data_i;
    if (hit && ready) begin
      sel_o = 4'(hit_idx + 1);
      op_o  = stage_data_i[hit_idx*DATA_W +: DATA_W];
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STAGES     = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     advance_i,
  input  logic [STAGES-1:0]        flush_mask_i,
  input  logic                     issue_valid_i,
  input  logic                     issue_wen_i,
  input  logic                     issue_load_i,
  input  logic [ADDR_W-1:0]        issue_waddr_i,
  input  logic [ADDR_W-1:0]        issue_rs_i,
  input  logic [ADDR_W-1:0]        issue_rt_i,
  input  logic [DATA_W-1:0]        rf_rs_data_i,
  input  logic [DATA_W-1:0]        rf_rt_data_i,
  input  logic [STAGES*DATA_W-1:0] stage_data_i,
  output logic [DATA_W-1:0]        opa_o,
  output logic [DATA_W-1:0]        opb_o,
  output logic [3:0]               fwd_sel_a_o,
  output logic [3:0]               fwd_sel_b_o,
  output logic                     stall_o,
  output logic [31:0]              stall_cnt_o
);
  logic [STAGES-1:0]             v_q, v_d, wen_q, wen_d, load_q, load_d;
  logic [STAGES-1:0][ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]                   stall_cnt_q;
  logic                          blocked_a, blocked_b;

  fwd_lookup #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAGES(STAGES),
               .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)) u_look_a (
    .v_i(v_q), .wen_i(wen_q), .load_i(load_q), .waddr_i(waddr_q),
    .addr_i(issue_rs_i), .rf_data_i(rf_rs_data_i), .stage_data_i(stage_data_i),
    .op_o(opa_o), .sel_o(fwd_sel_a_o), .blocked_o(blocked_a));

  fwd_lookup #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAGES(STAGES),
               .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)) u_look_b (
    .v_i(v_q), .wen_i(wen_q), .load_i(load_q), .waddr_i(waddr_q),
    .addr_i(issue_rt_i), .rf_data_i(rf_rt_data_i), .stage_data_i(stage_data_i),
    .op_o(opb_o), .sel_o(fwd_sel_b_o), .blocked_o(blocked_b));

  assign stall_o     = issue_valid_i && (blocked_a || blocked_b);
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    v_d     = v_q;
    wen_d   = wen_q;
    load_d  = load_q;
    waddr_d = waddr_q;
    if (advance_i) begin
      v_d     = {v_q[STAGES-2:0],     issue_valid_i && !stall_o};
      wen_d   = {wen_q[STAGES-2:0],   issue_wen_i};
      load_d  = {load_q[STAGES-2:0],  issue_load_i};
      waddr_d = {waddr_q[STAGES-2:0], issue_waddr_i};
    end
    // Flush applies to the post-edge slot, so it also kills a fresh entry 0.
    v_d = v_d & ~flush_mask_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q         <= '0;
      wen_q       <= '0;
      load_q      <= '0;
      waddr_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q     <= v_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      waddr_q <= waddr_d;
      if (advance_i && stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
endmodule
